button_press_classifier: RTL and testbench
==========================================

# button_press_classifier

Consumes the clean debounced level from the button debouncer and classifies each gesture into a one-cycle event: short press, long press, auto-repeat while held, or double click. Sits directly downstream of the debouncer and feeds UI/menu logic, which then never handles raw timing. Purely cycle-counted; timing constants are parameters.

## Interface
- `LONG_CYCLES`, default 8: held cycles that make a press "long" (must be ≥2).
- `GAP_CYCLES`, default 4: release window, in cycles, for a second press to count as a double click (must be ≥1).
- `REPEAT_CYCLES`, default 3: repeat period while long-held; 0 disables repeat.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `b_level`  input  1  debounced button level; 1 = pressed; synchronous to `clk`.
- `short_press`  output  1  one-cycle pulse: single press released before `LONG_CYCLES`, no second press.
- `long_press`  output  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_tick`  output  1  one-cycle pulse every `REPEAT_CYCLES` while long-held.
- `double_click`  output  1  one-cycle pulse on release of a second press.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- Registered `prev` holds last-cycle `b_level`. Rise = `b_level & ~prev`. `prev` resets to 1, so a button held through reset is ignored until released and re-pressed.
- States: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND.
- IDLE: on rise, go to PRESSED with cnt = 1.
- PRESSED:
  - `b_level` = 1 and cnt = `LONG_CYCLES`−1: pulse `long_press`, go to LONG_HELD, cnt = 0.
  - `b_level` = 1 otherwise: cnt++.
  - `b_level` = 0: go to WAIT_GAP, cnt = 1.
- LONG_HELD:
  - `b_level` = 1: cnt++. If `REPEAT_CYCLES` ≠ 0 and cnt+1 = `REPEAT_CYCLES`, pulse `repeat_tick` and set cnt = 0.
  - `b_level` = 0: go to IDLE. No other pulse.
- WAIT_GAP:
  - `b_level` = 1 at any edge while cnt ≤ `GAP_CYCLES`: go to SECOND. A re-press on the timeout edge counts as a double click.
  - `b_level` = 0 and cnt = `GAP_CYCLES`: pulse `short_press`, go to IDLE.
  - Otherwise: cnt++.
- SECOND:
  - `b_level` = 0: pulse `double_click`, go to IDLE.
  - Hold length is unclassified here: no long press or repeat.
- All outputs are registered. At most one event pulse is high in any cycle.
- Counter width = clog2(max(`LONG_CYCLES`, `GAP_CYCLES`+1, `REPEAT_CYCLES`)+1). The counter never wraps, because every terminal compare forces a state change or a clear.

## Timing
- Reset (`rst` low): state IDLE, cnt 0, `prev` 1, every output 0, effective immediately (async). Reset mid-gesture drops it with no pulse.
- Edge numbering: edge 0 is the first edge sampling `b_level` = 1 in IDLE.
  - `long_press` is registered at edge `LONG_CYCLES`−1 and visible in the following cycle.
  - `repeat_tick` is registered at edges `LONG_CYCLES`−1 + n·`REPEAT_CYCLES`, for n ≥ 1, while held.
- Release edge r is the first edge sampling 0 in PRESSED.
  - `short_press` is registered at edge r+`GAP_CYCLES` if `b_level` is 0 at edges r+1 … r+`GAP_CYCLES`.
  - A re-press sampled in that window goes to SECOND instead.
- `double_click` is registered at the first edge sampling 0 in SECOND.
- A re-press at r+`GAP_CYCLES`+1 arrives in IDLE one edge after `short_press` and starts a new gesture.
- `busy` rises the cycle after edge 0 and falls the cycle after the terminal pulse edge.

## Structure
- Package `button_pkg`: state encoding constants (3-bit), default cycle constants, and the clog2-based counter-width function.
- One sub-module, `press_timer`: a width-parameterised counter with load-1, clear, increment and terminal-compare outputs. It is shared across all states.
- The FSM and output registers live in `button_press_classifier`. Parameter legality is checked at elaboration.

## Test plan
All scenarios use `LONG_CYCLES`=8, `GAP_CYCLES`=4, `REPEAT_CYCLES`=3.
1. Hold 3 cycles, release at r, no re-press → single `short_press` registered at r+4; no other pulses; `busy` low afterwards.
2. Hold 14 cycles (edges 0–13) → `long_press` at edge 7, `repeat_tick` at edges 10 and 13; no pulse on release; `REPEAT_CYCLES`=0 run → no `repeat_tick`.
3. Hold exactly 7 cycles → `short_press` only. Hold exactly 8 → `long_press` at edge 7, no `short_press`.
4. Hold 2, release, re-press at r+4 (boundary), release → `double_click` only. Re-press at r+5 → `short_press` at r+4, then a new gesture.
5. Drive `rst` low in PRESSED at cnt 5 → all outputs 0 at once. Keep the button held through deassert → no events until release and re-press, then normal classification.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button press classifier.
// Holds the FSM state encoding, default timing constants and the counter-width helper.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_GAP  = 3'd3,
        ST_SECOND    = 3'd4
    } state_t;

    localparam int DEF_LONG_CYCLES   = 8;
    localparam int DEF_GAP_CYCLES    = 4;
    localparam int DEF_REPEAT_CYCLES = 3;

    // Wide enough to hold the largest terminal value any state compares against.
    function automatic int cnt_width(input int long_c, input int gap_c, input int rep_c);
        int m;
        m = long_c;
        if (gap_c + 1 > m) m = gap_c + 1;
        if (rep_c > m)     m = rep_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_press_classifier_press_timer.sv
// Shared gesture counter: load-1, clear and increment controls with fixed terminal compares.
// Clear wins over load-1, which wins over increment.
module press_timer #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] LONG_TC = '0,
    parameter logic [WIDTH-1:0] GAP_TC  = '0,
    parameter logic [WIDTH-1:0] REP_TC  = '0,
    parameter bit               REP_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load1,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_long,
    output logic o_at_gap,
    output logic o_at_rep
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= WIDTH'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_long = (r_cnt == LONG_TC);
    assign o_at_gap  = (r_cnt == GAP_TC);
    assign o_at_rep  = REP_EN && (r_cnt == REP_TC);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into one-cycle short/long/repeat/double-click events.
// state | meaning: IDLE wait for rise | PRESSED first press held | LONG_HELD past long threshold | WAIT_GAP released, watching for re-press | SECOND second press held
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic b_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic double_click,
    output logic busy
);

    localparam int CW = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] REP_TC  = (REPEAT_CYCLES == 0) ? '0 : CW'(REPEAT_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("LONG_CYCLES must be at least 2");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("GAP_CYCLES must be at least 1");
        end
        if (REPEAT_CYCLES < 0) begin : g_bad_rep
            $error("REPEAT_CYCLES must not be negative");
        end
    endgenerate

    state_t r_state;
    logic   r_prev;
    logic   r_short;
    logic   r_long;
    logic   r_repeat;
    logic   r_double;
    logic   r_busy;

    logic   w_rise;
    logic   w_load1;
    logic   w_clear;
    logic   w_inc;
    logic   w_at_long;
    logic   w_at_gap;
    logic   w_at_rep;

    // r_prev resets high so a button held through reset never looks like a new press.
    assign w_rise = b_level & ~r_prev;

    press_timer #(
        .WIDTH   (CW),
        .LONG_TC (LONG_TC),
        .GAP_TC  (GAP_TC),
        .REP_TC  (REP_TC),
        .REP_EN  (REPEAT_CYCLES != 0)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load1   (w_load1),
        .i_clear   (w_clear),
        .i_inc     (w_inc),
        .o_at_long (w_at_long),
        .o_at_gap  (w_at_gap),
        .o_at_rep  (w_at_rep)
    );

    always_comb begin
        w_load1 = 1'b0;
        w_clear = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_load1 = 1'b1;
                else        w_clear = 1'b1;
            end
            ST_PRESSED: begin
                if (!b_level)       w_load1 = 1'b1;
                else if (w_at_long) w_clear = 1'b1;
                else                w_inc   = 1'b1;
            end
            ST_LONG_HELD: begin
                // With repeat disabled the count parks at zero rather than running free.
                if (!b_level || w_at_rep)      w_clear = 1'b1;
                else if (REPEAT_CYCLES != 0)   w_inc   = 1'b1;
            end
            ST_WAIT_GAP: begin
                if (b_level || w_at_gap) w_clear = 1'b1;
                else                     w_inc   = 1'b1;
            end
            default: w_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_prev   <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_prev   <= b_level;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!b_level) begin
                        r_state <= ST_WAIT_GAP;
                    end else if (w_at_long) begin
                        r_long  <= 1'b1;
                        r_state <= ST_LONG_HELD;
                    end
                end
                ST_LONG_HELD: begin
                    if (!b_level) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_at_rep) begin
                        r_repeat <= 1'b1;
                    end
                end
                ST_WAIT_GAP: begin
                    // A re-press on the timeout edge still wins over the short press.
                    if (b_level) begin
                        r_state <= ST_SECOND;
                    end else if (w_at_gap) begin
                        r_short <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SECOND: begin
                    if (!b_level) begin
                        r_double <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign repeat_tick  = r_repeat;
    assign double_click = r_double;
    assign busy         = r_busy;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier: gestures with hand-computed event edges.
// Pulses are logged with the clock edge that registered them and compared per scenario.
module tb_button_press_classifier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b_level = 1'b0;

    logic sp, lp, rt, dc, bz;
    logic sp2, lp2, rt2, dc2, bz2;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;
    int multi    = 0;

    int q_short[$];
    int q_long[$];
    int q_rep[$];
    int q_dbl[$];
    int q_long2[$];
    int q_rep2[$];

    button_press_classifier #(
        .LONG_CYCLES(8), .GAP_CYCLES(4), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .b_level(b_level),
        .short_press(sp), .long_press(lp), .repeat_tick(rt),
        .double_click(dc), .busy(bz)
    );

    button_press_classifier #(
        .LONG_CYCLES(8), .GAP_CYCLES(4), .REPEAT_CYCLES(0)
    ) dut_norep (
        .clk(clk), .rst(rst), .b_level(b_level),
        .short_press(sp2), .long_press(lp2), .repeat_tick(rt2),
        .double_click(dc2), .busy(bz2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no = edge_no + 1;

    // A pulse seen at a negedge was registered by the preceding posedge, index edge_no-1.
    always @(negedge clk) begin
        if (rst) begin
            if (sp)  q_short.push_back(edge_no - 1);
            if (lp)  q_long.push_back(edge_no - 1);
            if (rt)  q_rep.push_back(edge_no - 1);
            if (dc)  q_dbl.push_back(edge_no - 1);
            if (lp2) q_long2.push_back(edge_no - 1);
            if (rt2) q_rep2.push_back(edge_no - 1);
            if ((32'(sp) + 32'(lp) + 32'(rt) + 32'(dc)) > 1) multi++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        q_short.delete();
        q_long.delete();
        q_rep.delete();
        q_dbl.delete();
        q_long2.delete();
        q_rep2.delete();
    endtask

    // Drive b for n cycles; first = index of the first edge that samples it.
    task automatic apply(input logic b, input int n, output int first);
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_level = b;
            if (i == 0) first = edge_no;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int t0, r, p, x, d;

    initial begin
        #1;
        check("reset_busy", int'(bz), 0);
        check("reset_pulses", int'({sp, lp, rt, dc}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 2, d);

        // 1: hold 3, release, no re-press
        clear_log();
        apply(1'b1, 3, t0);
        apply(1'b0, 8, r);
        settle();
        check("s1_short_cnt", q_short.size(), 1);
        check("s1_short_edge", q_at(q_short, 0), r + 4);
        check("s1_other_cnt", q_long.size() + q_rep.size() + q_dbl.size(), 0);
        check("s1_busy", int'(bz), 0);

        // 2: hold 14, long + two repeats; no-repeat instance gives long only
        clear_log();
        apply(1'b1, 14, t0);
        apply(1'b0, 6, r);
        settle();
        check("s2_long_cnt", q_long.size(), 1);
        check("s2_long_edge", q_at(q_long, 0), t0 + 7);
        check("s2_rep_cnt", q_rep.size(), 2);
        check("s2_rep_edge0", q_at(q_rep, 0), t0 + 10);
        check("s2_rep_edge1", q_at(q_rep, 1), t0 + 13);
        check("s2_no_short_dbl", q_short.size() + q_dbl.size(), 0);
        check("s2_norep_long_edge", q_at(q_long2, 0), t0 + 7);
        check("s2_norep_rep_cnt", q_rep2.size(), 0);
        check("s2_busy", int'(bz), 0);

        // 3a: hold exactly 7 -> short only
        clear_log();
        apply(1'b1, 7, t0);
        apply(1'b0, 8, r);
        settle();
        check("s3a_short_edge", q_at(q_short, 0), t0 + 11);
        check("s3a_short_cnt", q_short.size(), 1);
        check("s3a_long_cnt", q_long.size(), 0);

        // 3b: hold exactly 8 -> long at edge 7, nothing else
        clear_log();
        apply(1'b1, 8, t0);
        apply(1'b0, 8, r);
        settle();
        check("s3b_long_edge", q_at(q_long, 0), t0 + 7);
        check("s3b_long_cnt", q_long.size(), 1);
        check("s3b_other_cnt", q_short.size() + q_rep.size() + q_dbl.size(), 0);

        // 4a: re-press on the timeout edge r+4 -> double click
        clear_log();
        apply(1'b1, 2, t0);
        apply(1'b0, 4, r);
        apply(1'b1, 2, p);
        apply(1'b0, 6, x);
        settle();
        check("s4a_dbl_cnt", q_dbl.size(), 1);
        check("s4a_dbl_edge", q_at(q_dbl, 0), x);
        check("s4a_other_cnt", q_short.size() + q_long.size() + q_rep.size(), 0);
        check("s4a_busy", int'(bz), 0);

        // 4b: re-press at r+5 -> short at r+4, then a fresh short gesture
        clear_log();
        apply(1'b1, 2, t0);
        apply(1'b0, 5, r);
        apply(1'b1, 2, p);
        apply(1'b0, 6, x);
        settle();
        check("s4b_short_cnt", q_short.size(), 2);
        check("s4b_short_edge0", q_at(q_short, 0), r + 4);
        check("s4b_short_edge1", q_at(q_short, 1), x + 4);
        check("s4b_dbl_cnt", q_dbl.size(), 0);

        // 5: reset mid-press at cnt 5, keep holding through deassert
        clear_log();
        apply(1'b1, 5, t0);
        @(posedge clk);
        #2;
        check("s5_busy_before", int'(bz), 1);
        rst = 1'b0;
        #1;
        check("s5_busy_async", int'(bz), 0);
        check("s5_busy2_async", int'(bz2), 0);
        check("s5_pulses_async", int'({sp, lp, rt, dc}), 0);
        @(negedge clk);
        rst = 1'b1;
        apply(1'b1, 12, d);
        settle();
        check("s5_held_events", q_short.size() + q_long.size() + q_rep.size() + q_dbl.size(), 0);
        check("s5_held_busy", int'(bz), 0);
        apply(1'b0, 3, d);
        clear_log();
        apply(1'b1, 3, t0);
        apply(1'b0, 8, r);
        settle();
        check("s5_short_edge", q_at(q_short, 0), r + 4);
        check("s5_short_cnt", q_short.size(), 1);
        check("s5_other_cnt", q_long.size() + q_rep.size() + q_dbl.size(), 0);

        check("one_hot_events", multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
